collision_detect: RTL and testbench

- Per-frame geometric collision detector; sits directly upstream of ball_pos_ctrl.
- Drives its pl1_col, pl2_col, net_col inputs, which are currently tied off or driven by the test pin.
- On each frame tick, samples ball and both player positions and evaluates collisions over a fixed multi-cycle schedule, sharing a single multiplier.
- Reports per-object collision flags with a one-cycle valid strobe. All coordinates are sprite top-left corners in 1024x768 screen space.

---
 rtl/collision_detect_if.sv | 26 ++
 rtl/collision_detect.sv | 206 ++++++++++++++++++++
 tb/tb_collision_detect.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/collision_detect_if.sv
// Frame-tick, position and collision-flag bundle between the game logic and collision_detect.
interface collision_detect_if;
    logic        frame_tick;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] pl2_posx;
    logic [11:0] pl2_posy;
    logic        pl1_col;
    logic        pl2_col;
    logic        net_col;
    logic        gnd_col;
    logic        col_valid;
    logic        busy;

    modport master (
        output frame_tick, ball_posx, ball_posy, pl1_posx, pl1_posy, pl2_posx, pl2_posy,
        input  pl1_col, pl2_col, net_col, gnd_col, col_valid, busy
    );

    modport slave (
        input  frame_tick, ball_posx, ball_posy, pl1_posx, pl1_posy, pl2_posx, pl2_posy,
        output pl1_col, pl2_col, net_col, gnd_col, col_valid, busy
    );
endinterface

// File: rtl/collision_detect.sv
// Per-frame ball/player/net/ground collision detector using one shared squaring multiplier.
// Optional macro COLLISION_COOLDOWN_EN masks repeated player hits for COOLDOWN_FRAMES evaluations.
module collision_detect #(
    parameter int BALL_R = 32,
    parameter int PL_R   = 40,
    parameter int PL_W   = 80,
    parameter int NET_X  = 508,
    parameter int NET_W  = 8,
    parameter int NET_Y  = 450,
    parameter int GND_Y  = 700
`ifdef COLLISION_COOLDOWN_EN
    ,
    parameter int COOLDOWN_FRAMES = 8
`endif
) (
    input logic              clk,
    input logic              rst,
    collision_detect_if.slave cd
);

    typedef enum logic [3:0] {
        IDLE, CAPTURE, SQ1X, SQ1Y, CMP1, SQ2X, SQ2Y, CMP2, NETGND, OUT
    } state_t;

    localparam logic [12:0] BALL_R13  = 13'(BALL_R);
    localparam logic [12:0] BALL_D13  = 13'(2 * BALL_R);
    localparam logic [12:0] PL_R13    = 13'(PL_R);
    localparam logic [12:0] PL_HW13   = 13'(PL_W / 2);
    localparam logic [12:0] NET_L13   = 13'(NET_X);
    localparam logic [12:0] NET_R13   = 13'(NET_X + NET_W);
    localparam logic [12:0] NET_T13   = 13'(NET_Y);
    localparam logic [12:0] GND_Y13   = 13'(GND_Y);
    localparam logic [26:0] HIT_R2    = 27'((BALL_R + PL_R) * (BALL_R + PL_R));

    state_t state, state_next;
    logic   busy_c;

    logic [11:0] ball_x, ball_y, p1_x, p1_y, p2_x, p2_y;
    logic [25:0] sq_x, sq_y;
    logic        hit1, hit2, net_hit, gnd_hit;
    logic        pl1_q, pl2_q, net_q, gnd_q, valid_q;
    logic        pl1_eff, pl2_eff;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy_c     = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (cd.frame_tick) state_next = CAPTURE;
            end
            CAPTURE: state_next = SQ1X;
            SQ1X:    state_next = SQ1Y;
            SQ1Y:    state_next = CMP1;
            CMP1:    state_next = SQ2X;
            SQ2X:    state_next = SQ2Y;
            SQ2Y:    state_next = CMP2;
            CMP2:    state_next = NETGND;
            NETGND:  state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Sprite centres in 13 bits so the signed differences cannot overflow on screen coordinates.
    logic [12:0]        ball_cx, ball_cy, p1_cx, p1_cy, p2_cx, p2_cy;
    logic signed [12:0] dx1, dy1, dx2, dy2, mul_op;
    logic signed [25:0] prod;
    logic [25:0]        sq;
    logic [26:0]        sq_sum;

    always_comb begin
        ball_cx = {1'b0, ball_x} + BALL_R13;
        ball_cy = {1'b0, ball_y} + BALL_R13;
        p1_cx   = {1'b0, p1_x} + PL_HW13;
        p1_cy   = {1'b0, p1_y} + PL_R13;
        p2_cx   = {1'b0, p2_x} + PL_HW13;
        p2_cy   = {1'b0, p2_y} + PL_R13;
        dx1     = signed'(ball_cx - p1_cx);
        dy1     = signed'(ball_cy - p1_cy);
        dx2     = signed'(ball_cx - p2_cx);
        dy2     = signed'(ball_cy - p2_cy);
    end

    always_comb begin
        mul_op = '0;
        case (state)
            SQ1X:    mul_op = dx1;
            SQ1Y:    mul_op = dy1;
            SQ2X:    mul_op = dx2;
            SQ2Y:    mul_op = dy2;
            default: mul_op = '0;
        endcase
    end

    assign prod   = mul_op * mul_op;
    assign sq     = unsigned'(prod);
    assign sq_sum = {1'b0, sq_x} + {1'b0, sq_y};

    logic [12:0] ball_x13, ball_y13;
    logic        net_c, gnd_c;

    always_comb begin
        ball_x13 = {1'b0, ball_x};
        ball_y13 = {1'b0, ball_y};
        net_c    = (ball_x13 + BALL_D13 > NET_L13) && (ball_x13 < NET_R13) &&
                   (ball_y13 + BALL_D13 > NET_T13);
        gnd_c    = (ball_y13 + BALL_D13 >= GND_Y13);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ball_x  <= '0;
            ball_y  <= '0;
            p1_x    <= '0;
            p1_y    <= '0;
            p2_x    <= '0;
            p2_y    <= '0;
            sq_x    <= '0;
            sq_y    <= '0;
            hit1    <= 1'b0;
            hit2    <= 1'b0;
            net_hit <= 1'b0;
            gnd_hit <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    ball_x <= cd.ball_posx;
                    ball_y <= cd.ball_posy;
                    p1_x   <= cd.pl1_posx;
                    p1_y   <= cd.pl1_posy;
                    p2_x   <= cd.pl2_posx;
                    p2_y   <= cd.pl2_posy;
                end
                SQ1X, SQ2X: sq_x <= sq;
                SQ1Y, SQ2Y: sq_y <= sq;
                CMP1:       hit1 <= (sq_sum <= HIT_R2);
                CMP2:       hit2 <= (sq_sum <= HIT_R2);
                NETGND: begin
                    net_hit <= net_c;
                    gnd_hit <= gnd_c;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_COOLDOWN_EN
    localparam int CD_W = ($clog2(COOLDOWN_FRAMES + 1) > 4) ? $clog2(COOLDOWN_FRAMES + 1) : 4;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic [CD_W-1:0] cd1, cd2;

    // A running counter hides the hit entirely; reloading only happens once it has drained.
    assign pl1_eff = hit1 && (cd1 == '0);
    assign pl2_eff = hit2 && (cd2 == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cd1 <= '0;
            cd2 <= '0;
        end else if (state == OUT) begin
            if (cd1 != '0)  cd1 <= cd1 - CD_W'(1);
            else if (hit1)  cd1 <= CD_LOAD;
            if (cd2 != '0)  cd2 <= cd2 - CD_W'(1);
            else if (hit2)  cd2 <= CD_LOAD;
        end
    end
`else
    assign pl1_eff = hit1;
    assign pl2_eff = hit2;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pl1_q   <= 1'b0;
            pl2_q   <= 1'b0;
            net_q   <= 1'b0;
            gnd_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state == OUT);
            if (state == OUT) begin
                pl1_q <= pl1_eff;
                pl2_q <= pl2_eff;
                net_q <= net_hit;
                gnd_q <= gnd_hit;
            end
        end
    end

    assign cd.pl1_col   = pl1_q;
    assign cd.pl2_col   = pl2_q;
    assign cd.net_col   = net_q;
    assign cd.gnd_col   = gnd_q;
    assign cd.col_valid = valid_q;
    assign cd.busy      = busy_c;

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect: latency, geometry boundaries, busy/reset handling, cooldown.
module tb_collision_detect;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cd1_m = 0;
    int   cd2_m = 0;

    collision_detect_if ifc ();

    collision_detect dut (
        .clk (clk),
        .rst (rst),
        .cd  (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {ifc.pl1_col, ifc.pl2_col, ifc.net_col, ifc.gnd_col};
    endfunction

    // Cooldown expectation: an active count hides the hit and drains by one per evaluation.
    task automatic mask_player(input logic raw, inout int cnt, output logic eff);
`ifdef COLLISION_COOLDOWN_EN
        if (cnt != 0) begin
            eff = 1'b0;
            cnt--;
        end else begin
            eff = raw;
            if (raw) cnt = 8;
        end
`else
        eff = raw;
        cnt = 0;
`endif
    endtask

    task automatic set_pos(input logic [11:0] bx, by, p1x, p1y, p2x, p2y);
        ifc.ball_posx = bx;
        ifc.ball_posy = by;
        ifc.pl1_posx  = p1x;
        ifc.pl1_posy  = p1y;
        ifc.pl2_posx  = p2x;
        ifc.pl2_posy  = p2y;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cd1_m = 0;
        cd2_m = 0;
    endtask

    // One evaluation; raw expected flags are hand computed, retick adds a tick while busy.
    task automatic run_frame(input string tag, input logic [11:0] bx, by, p1x, p1y, p2x, p2y,
                             input logic e1, e2, en, eg, input bit retick);
        logic m1, m2;
        int   hits, at;
        mask_player(e1, cd1_m, m1);
        mask_player(e2, cd2_m, m2);
        set_pos(bx, by, p1x, p1y, p2x, p2y);
        @(negedge clk) ifc.frame_tick = 1'b1;
        @(posedge clk);
        #1 ifc.frame_tick = 1'b0;
        hits = 0;
        at   = -1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check({tag, ".busy"}, 32'(ifc.busy), 32'd1);
                // Scramble live inputs; the captured frame must be unaffected.
                set_pos(12'd510, 12'd690, 12'd490, 12'd650, 12'd490, 12'd650);
            end
            if (retick && k == 2) ifc.frame_tick = 1'b1;
            if (retick && k == 3) ifc.frame_tick = 1'b0;
            if (ifc.col_valid) begin
                hits++;
                if (at < 0) at = k;
                if (k == 9) check({tag, ".flags"}, 32'(flags()), 32'({m1, m2, en, eg}));
            end
        end
        check({tag, ".latency"}, 32'(at), 32'd9);
        check({tag, ".pulses"}, 32'(hits), 32'd1);
        check({tag, ".hold"}, 32'(flags()), 32'({m1, m2, en, eg}));
    endtask

    initial begin
        ifc.frame_tick = 1'b0;
        set_pos('0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.outs", 32'({flags(), ifc.col_valid, ifc.busy}), 32'd0);
        rst = 1'b1;

        // Player 1 hit: dx=12, dy=-53
        run_frame("p1hit", 12'd200, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulled for two cycles while in SQ1Y
        set_pos(12'd200, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325);
        @(negedge clk) ifc.frame_tick = 1'b1;
        @(posedge clk);
        #1 ifc.frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.outs", 32'({flags(), ifc.col_valid, ifc.busy}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cd1_m = 0;
        cd2_m = 0;
        begin
            int pulses = 0;
            for (int k = 0; k < 15; k++) begin
                @(posedge clk);
                #1;
                if (ifc.col_valid) pulses++;
            end
            check("midrst.novalid", 32'(pulses), 32'd0);
        end
        run_frame("afterrst", 12'd200, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Tangency: dx=72 hits, dx=73 misses
        do_reset();
        run_frame("tangent", 12'd260, 12'd333, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_frame("tangent+1", 12'd261, 12'd333, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Net and ground boundaries, then player 2 alone and player 2 plus net together
        run_frame("net", 12'd480, 12'd420, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame("gnd700", 12'd100, 12'd636, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("gnd699", 12'd100, 12'd635, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("netedge", 12'd444, 12'd420, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("p2hit", 12'd820, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_frame("p2net", 12'd480, 12'd420, 12'd180, 12'd325, 12'd520, 12'd400,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Second tick three cycles in must be dropped
        do_reset();
        run_frame("busytick", 12'd200, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Ten consecutive evaluations of the player 1 hit geometry
        do_reset();
        for (int i = 1; i <= 10; i++)
            run_frame($sformatf("cool%0d", i), 12'd200, 12'd280, 12'd180, 12'd325, 12'd800, 12'd325,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
